// File: rtl/temp_sample_ctrl_pkg.sv
// Shared temperature definitions: FSM state encodings, reading width and the
// fraction scaling used to turn 1/16 C steps into a tenths digit.
package temp_sample_ctrl_pkg;

  localparam int RAW_W      = 12;
  localparam int FRAC_SCALE = 10;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_DONE,
    ABS,
    CONV,
    OUT,
    WAIT_PER
  } state_t;

  // Tenths digit from a 1/16 fraction nibble, truncating.
  function automatic logic [3:0] frac_tenths(input logic [3:0] f);
    return 4'(({4'b0, f} * 8'(FRAC_SCALE)) >> 4);
  endfunction

endpackage

// File: rtl/temp_sample_ctrl_bin2bcd8.sv
// Sequential double-dabble: one input bit per clock, MSB first, 8 clocks
// from load to a settled 3-digit result.
module bin2bcd8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0]  sh;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [3:0]  cnt;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= 4'd8;
    end else if (cnt != '0) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt - 4'd1;
    end
  end

  // done marks the cycle whose edge performs the final shift
  assign busy     = (cnt != '0);
  assign done     = (cnt == 4'd1);
  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign ones     = bcd[3:0];

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic temperature sampler: triggers a sensor read, captures the 12-bit
// reading and converts its magnitude to BCD integer digits plus a tenths digit.
module temp_sample_ctrl
  import temp_sample_ctrl_pkg::*;
#(
  parameter int PERIOD  = 100000000,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             start,
  input  logic             done_i,
  input  logic [7:0]       msb_i,
  input  logic [7:0]       lsb_i,
  output logic [RAW_W-1:0] raw,
  output logic             neg,
  output logic [3:0]       bcd_h,
  output logic [3:0]       bcd_t,
  output logic [3:0]       bcd_o,
  output logic [3:0]       bcd_f,
  output logic             valid,
  output logic             err
);

  // state     | meaning
  // IDLE      | sampling disabled
  // ARM       | start pulse, period timer restarts
  // WAIT_DONE | waiting for sensor read, timeout running
  // ABS       | magnitude and tenths computed, converter loaded
  // CONV      | double-dabble in progress
  // OUT       | publish results and pulse valid
  // WAIT_PER  | waiting for the next sample slot

  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [PW-1:0]     per_cnt;
  logic [TW-1:0]     to_cnt;
  logic              per_done, to_done;
  logic [RAW_W-1:0]  raw_lat;
  logic [RAW_W-1:0]  mag;
  logic              neg_lat;
  logic [3:0]        frac_lat;
  logic              conv_load, conv_busy, conv_done;
  logic [3:0]        conv_h, conv_t, conv_o;
  logic              unused_lsb;

  assign unused_lsb = ^lsb_i[3:0];
  assign per_done   = (per_cnt == '0);
  assign to_done    = (to_cnt == '0);

  // 12-bit unsigned magnitude is exact: -2048 wraps to 0x800 = 2048
  assign mag = raw_lat[RAW_W-1] ? (RAW_W'(0) - raw_lat) : raw_lat;

  bin2bcd8 u_bin2bcd8 (
    .clk      (clk),
    .rst      (rst),
    .load     (conv_load),
    .bin      (mag[11:4]),
    .busy     (conv_busy),
    .done     (conv_done),
    .hundreds (conv_h),
    .tens     (conv_t),
    .ones     (conv_o)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    err       = 1'b0;
    conv_load = 1'b0;
    case (state)
      IDLE:      if (enable) state_nxt = ARM;
      ARM: begin
        start     = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) begin
          state_nxt = ABS;
        end else if (to_done) begin
          err       = 1'b1;
          state_nxt = per_done ? ARM : WAIT_PER;
        end
      end
      ABS: begin
        conv_load = 1'b1;
        state_nxt = CONV;
      end
      CONV:      if (conv_done || !conv_busy) state_nxt = OUT;
      OUT:       state_nxt = per_done ? ARM : WAIT_PER;
      WAIT_PER:  if (per_done) state_nxt = ARM;
      default:   state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      err       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      per_cnt  <= '0;
      to_cnt   <= '0;
      raw_lat  <= '0;
      neg_lat  <= 1'b0;
      frac_lat <= '0;
      raw      <= '0;
      neg      <= 1'b0;
      bcd_h    <= '0;
      bcd_t    <= '0;
      bcd_o    <= '0;
      bcd_f    <= '0;
      valid    <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      // ARM is period cycle 0, so the next cycle holds PERIOD-2
      if (state == ARM) begin
        per_cnt <= PW'(PERIOD - 2);
        to_cnt  <= TW'(TIMEOUT - 1);
      end else begin
        if (!per_done) per_cnt <= per_cnt - 1'b1;
        if (state == WAIT_DONE && !to_done) to_cnt <= to_cnt - 1'b1;
      end
      if (state == WAIT_DONE && done_i) raw_lat <= {msb_i, lsb_i[7:4]};
      if (state == ABS) begin
        neg_lat  <= raw_lat[RAW_W-1];
        frac_lat <= frac_tenths(mag[3:0]);
      end
      if (state == OUT && enable) begin
        raw   <= raw_lat;
        neg   <= neg_lat;
        bcd_h <= conv_h;
        bcd_t <= conv_t;
        bcd_o <= conv_o;
        bcd_f <= frac_lat;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed bench for temp_sample_ctrl with PERIOD=50, TIMEOUT=20; the bench
// plays the sensor read FSM and checks timing and converted values.
module tb_temp_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        start;
  logic        done_i = 1'b0;
  logic [7:0]  msb_i = '0;
  logic [7:0]  lsb_i = '0;
  logic [11:0] raw;
  logic        neg;
  logic [3:0]  bcd_h, bcd_t, bcd_o, bcd_f;
  logic        valid;
  logic        err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;

  temp_sample_ctrl #(.PERIOD(50), .TIMEOUT(20)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .start  (start),
    .done_i (done_i),
    .msb_i  (msb_i),
    .lsb_i  (lsb_i),
    .raw    (raw),
    .neg    (neg),
    .bcd_h  (bcd_h),
    .bcd_t  (bcd_t),
    .bcd_o  (bcd_o),
    .bcd_f  (bcd_f),
    .valid  (valid),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid) valid_cnt <= valid_cnt + 1;
  end

  // msb, lsb -> raw, neg, hundreds, tens, ones, tenths (hand-computed)
  logic [7:0]  v_msb [7] = '{8'h19, 8'hE7, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h12};
  logic [7:0]  v_lsb [7] = '{8'h00, 8'h00, 8'h00, 8'hF0, 8'h80, 8'hF0, 8'h3C};
  logic [11:0] v_raw [7] = '{12'h190, 12'hE70, 12'h800, 12'h7FF, 12'h008, 12'hFFF, 12'h123};
  logic        v_neg [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0]  v_h   [7] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
  logic [3:0]  v_t   [7] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd1};
  logic [3:0]  v_o   [7] = '{4'd5, 4'd5, 4'd8, 4'd7, 4'd0, 4'd0, 4'd8};
  logic [3:0]  v_f   [7] = '{4'd0, 4'd0, 4'd0, 4'd9, 4'd5, 4'd0, 4'd1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(output int t);
    t = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (start) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("start_timeout", start, 1);
  endtask

  // called at the negedge of the ARM cycle
  task automatic do_read(input int k);
    int d;
    int v;
    v = -1;
    @(negedge clk);
    done_i = 1'b1;
    msb_i  = v_msb[k];
    lsb_i  = v_lsb[k];
    d      = cyc + 1;
    @(negedge clk);
    done_i = 1'b0;
    msb_i  = '0;
    lsb_i  = '0;
    for (int i = 0; i < 30; i++) begin
      if (valid) begin
        v = cyc;
        break;
      end
      @(negedge clk);
    end
    if (v < 0) begin
      chk($sformatf("valid_timeout_%0d", k), valid, 1);
      return;
    end
    chk($sformatf("latency_%0d", k), v - d, 10);
    chk($sformatf("raw_%0d", k), raw, v_raw[k]);
    chk($sformatf("neg_%0d", k), neg, v_neg[k]);
    chk($sformatf("bcd_%0d", k), {bcd_h, bcd_t, bcd_o}, {v_h[k], v_t[k], v_o[k]});
    chk($sformatf("bcd_f_%0d", k), bcd_f, v_f[k]);
    @(negedge clk);
    chk($sformatf("valid_pulse_%0d", k), valid, 0);
  endtask

  initial begin
    int s_prev, s_now, e_t, vc;

    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_raw", raw, 0);
    chk("rst_digits", {neg, bcd_h, bcd_t, bcd_o, bcd_f}, 0);

    rst = 1'b1;
    enable = 1'b1;
    wait_start(s_prev);
    do_read(0);
    for (int k = 1; k < 7; k++) begin
      wait_start(s_now);
      chk($sformatf("spacing_%0d", k), s_now - s_prev, 50);
      s_prev = s_now;
      do_read(k);
    end

    // timeout: no done_i after start
    wait_start(s_now);
    chk("spacing_to", s_now - s_prev, 50);
    s_prev = s_now;
    vc = valid_cnt;
    e_t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err) begin
        e_t = cyc;
        break;
      end
    end
    if (e_t < 0) chk("err_timeout", err, 1);
    else chk("err_delay", e_t - s_prev, 20);
    @(negedge clk);
    chk("err_pulse", err, 0);

    // stray done_i while waiting for the period
    @(negedge clk);
    done_i = 1'b1;
    msb_i  = 8'h55;
    lsb_i  = 8'hA0;
    @(negedge clk);
    done_i = 1'b0;
    wait_start(s_now);
    chk("spacing_after_err", s_now - s_prev, 50);
    chk("no_valid_err", valid_cnt, vc);
    chk("stray_raw", raw, 12'h123);

    // enable dropped during conversion
    @(negedge clk);
    done_i = 1'b1;
    msb_i  = 8'h0A;
    lsb_i  = 8'h00;
    @(negedge clk);
    done_i = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    vc = valid_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("dis_start", start, 0);
    end
    chk("dis_no_valid", valid_cnt, vc);
    chk("dis_hold_raw", raw, 12'h123);
    chk("dis_hold_bcd", {neg, bcd_h, bcd_t, bcd_o, bcd_f}, {1'b0, 4'd0, 4'd1, 4'd8, 4'd1});
    enable = 1'b1;
    @(negedge clk);
    chk("reen_start", start, 1);

    // reset in WAIT_DONE with a simultaneous done_i
    @(negedge clk);
    rst    = 1'b0;
    done_i = 1'b1;
    msb_i  = 8'h19;
    lsb_i  = 8'h00;
    @(negedge clk);
    chk("mid_rst_raw", raw, 0);
    chk("mid_rst_digits", {neg, bcd_h, bcd_t, bcd_o, bcd_f}, 0);
    chk("mid_rst_flags", {start, valid, err}, 0);
    rst    = 1'b1;
    done_i = 1'b0;
    wait_start(s_now);
    do_read(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/temp_sample_ctrl.md
TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 100000000, meaning clocks between successive start pulses.
REQ-002 SHALL have parameter TIMEOUT, default 1000000, meaning the maximum number of clocks to wait for done_i after start.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  in  1  high = periodic sampling runs.
REQ-006 SHALL have port start  out  1  one-cycle pulse to the I2C sensor read FSM.
REQ-007 SHALL have port done_i  in  1  one-cycle pulse from the read FSM: msb_i/lsb_i valid.
REQ-008 SHALL have port msb_i  in  8  sensor MSB byte.
REQ-009 SHALL have port lsb_i  in  8  sensor LSB byte.
REQ-010 SHALL have port raw  out  12  captured two's-complement reading {msb_i, lsb_i[7:4]}, 0.0625 C/LSB.
REQ-011 SHALL have port neg  out  1  reading is negative.
REQ-012 SHALL have ports bcd_h, bcd_t, bcd_o  out  4 each  hundreds/tens/ones of integer magnitude.
REQ-013 SHALL have port bcd_f  out  4  tenths digit of fraction.
REQ-014 SHALL have port valid  out  1  one-cycle pulse: raw, neg and BCD outputs updated.
REQ-015 SHALL have port err  out  1  one-cycle pulse on timeout.

Function
REQ-016 SHALL use states IDLE, ARM, WAIT_DONE, ABS, CONV, OUT, WAIT_PER.
- IDLE -> ARM when enable=1.
- ARM: start=1 for exactly one cycle; period counter cleared; -> WAIT_DONE.
- WAIT_DONE: done_i=1 -> latch raw, -> ABS; timeout counter reaches TIMEOUT-1 -> err=1, -> WAIT_PER.
- ABS -> CONV; CONV runs exactly 8 cycles -> OUT; OUT: valid=1 -> WAIT_PER.
- WAIT_PER -> ARM when the period counter reaches PERIOD-1.
REQ-017 SHALL run the period counter from the ARM cycle, so start-to-start spacing is exactly PERIOD clocks when conversion plus wait ends earlier.
REQ-018 SHALL, when PERIOD elapses before WAIT_PER is reached, go to ARM in the cycle after OUT or err and skip no further samples.
REQ-019 SHALL ignore done_i in every state except WAIT_DONE.
REQ-020 SHALL, in ABS, compute mag = |raw| (13-bit result, so -2048 -> 2048), int = mag[11:4] (0..128) and bcd_f = (mag[3:0]*10)>>4 (truncating).
REQ-021 SHALL convert int to 3 BCD digits by sequential double-dabble, one bit per CONV cycle, MSB first.
REQ-022 SHALL pulse valid exactly 10 clocks after the edge that samples done_i.
REQ-023 SHALL hold raw, neg and the BCD outputs stable between valid pulses.
REQ-024 SHALL force the FSM to IDLE in the next cycle when enable=0 in any state, abandon the conversion in progress, emit no valid or err, and hold the outputs.
REQ-025 SHALL report -0 as neg=0; neg=1 only when raw[11]=1.

Reset
REQ-026 SHALL, when rst=0 on a clock edge, set state=IDLE, clear all counters, and zero start, valid, err, raw, neg and all BCD digits.
REQ-027 SHALL give rst priority over enable and done_i; rst mid-conversion discards the conversion.

Structure
REQ-028 SHALL take state encodings, the raw width (12) and the fraction scale constant from the shared temperature definitions package.
REQ-029 SHALL implement double-dabble as sub-module bin2bcd8 (8-bit in, 3 digits out, load/busy/done handshake); the FSM and counters remain in the top module.

Verification
REQ-030 SHALL cover: PERIOD=50, TIMEOUT=20; msb=0x19, lsb=0x00 -> raw=0x190, neg=0, digits 0/2/5, bcd_f=0, valid 10 clocks after done_i.
REQ-031 SHALL cover: msb=0xE7, lsb=0x00 -> raw=0xE70, neg=1, digits 0/2/5, bcd_f=0; and msb=0x80, lsb=0x00 -> neg=1, digits 1/2/8, bcd_f=0.
REQ-032 SHALL cover: msb=0x7F, lsb=0xF0 -> digits 1/2/7, bcd_f=9; and msb=0x00, lsb=0x80 -> digits 0/0/0, bcd_f=5, neg=0.
REQ-033 SHALL cover: no done_i after start -> err pulse 20 clocks after start, no valid, next start 50 clocks after the previous one.
REQ-034 SHALL cover: enable dropped during CONV -> no valid, outputs unchanged, IDLE next cycle; enable re-raised -> start the next cycle.
REQ-035 SHALL cover: rst=0 asserted mid-WAIT_DONE -> all outputs 0 on the next edge; a stray done_i during WAIT_PER is ignored.
